// File: rtl/nibble_alu_sequencer_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: op codes,
// FSM state encoding and the op legality check.
package nibble_alu_sequencer_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only the five op codes above are meaningful to the slice.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // Ops whose word-level carry out is meaningful.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/nibble_alu_sequencer.sv
// Drives an external 4-bit ALU slice one nibble per clock (LSB first),
// rippling the carry through a register and assembling the word result.
module nibble_alu_sequencer
  import nibble_alu_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             illegal_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cin,
  output logic             alu_less,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_cout,
  input  logic             alu_set
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  // Next-state and registered-output computation for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cout_d    = cout_q;
    zero_d    = zero_q;
    illegal_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          idx_d   = '0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
          zero_d  = 1'b0;
          busy_d  = 1'b1;
          if (is_legal_op(op)) begin
            state_d = ST_RUN;
          end else begin
            // Illegal ops skip the slice entirely and report at once.
            state_d   = ST_DONE;
            done_d    = 1'b1;
            illegal_d = 1'b1;
            result_d  = '0;
            zero_d    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = alu_result;
        carry_d = alu_cout;
        if (idx_q == LAST_IDX) begin
          // SLT: the sign of A-B from the top nibble becomes the whole word.
          if (op_q == OP_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, alu_set};
          end
          cout_d  = is_arith_op(op_q) ? alu_cout : 1'b0;
          zero_d  = (result_d == '0);
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 3'b000;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cout_q    <= cout_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // Slice drive is decoded straight from the latched operands and index.
  always_comb begin
    alu_a    = a_q[{idx_q, 2'b00} +: 4];
    alu_b    = b_q[{idx_q, 2'b00} +: 4];
    alu_op   = op_q;
    alu_less = 1'b0;
    if (idx_q == '0) begin
      alu_cin = (op_q == OP_SUB) || (op_q == OP_SLT);
    end else begin
      alu_cin = carry_q;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign cout       = cout_q;
  assign zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Bench: sequencer paired with a behavioural 4-bit ALU slice, checked
// against a word-level arithmetic reference model.
module tb_nibble_alu_sequencer;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         busy, done, cout, zero, illegal_op;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_result;
  logic         alu_cin, alu_less, alu_cout, alu_set;
  logic [2:0]   alu_op;

  int tests = 0;
  int fails = 0;
  int done_count = 0;

  nibble_alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
    .illegal_op(illegal_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_less(alu_less), .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout), .alu_set(alu_set)
  );

  always #5 clk = ~clk;

  // 4-bit slice: op[2] inverts B, op[1:0] selects AND/OR/SUM/LESS.
  logic [3:0] sl_b;
  logic [4:0] sl_sum;
  always_comb begin
    sl_b   = alu_op[2] ? ~alu_b : alu_b;
    sl_sum = {1'b0, alu_a} + {1'b0, sl_b} + {4'b0, alu_cin};
    case (alu_op[1:0])
      2'b00:   alu_result = alu_a & sl_b;
      2'b01:   alu_result = alu_a | sl_b;
      2'b10:   alu_result = sl_sum[3:0];
      default: alu_result = {3'b000, alu_less};
    endcase
    alu_cout = sl_sum[4];
    alu_set  = sl_sum[3];
  end

  always @(posedge clk) if (done) done_count <= done_count + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word-level reference: plain arithmetic on the full operands.
  task automatic model(input logic [2:0] o, input logic [W-1:0] av, bv,
                       output logic [W-1:0] r, output logic c, output logic ill);
    logic [W-1:0] diff;
    diff = av - bv;
    ill = 1'b0; c = 1'b0; r = '0;
    case (o)
      3'b000: r = av & bv;
      3'b001: r = av | bv;
      3'b010: begin r = av + bv; c = (int'(av) + int'(bv)) > 65535; end
      3'b110: begin r = diff; c = (av >= bv); end
      3'b111: begin r = {15'b0, diff[W-1]}; c = (av >= bv); end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic do_op(input string name, input logic [2:0] o,
                       input logic [W-1:0] av, bv, input bit pester);
    logic [W-1:0] er;
    logic ec, eill;
    int cyc, dc0;
    model(o, av, bv, er, ec, eill);
    @(negedge clk);
    start = 1'b1; op_i = o; a_i = av; b_i = bv;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); op_i = 3'($urandom);
    dc0 = done_count;
    check({name, ".busy0"}, 32'(busy), 32'd1);
    if (!eill) begin
      check({name, ".cin0"}, 32'(alu_cin), 32'((o == 3'b110) || (o == 3'b111)));
      check({name, ".alu_a0"}, 32'(alu_a), 32'(av[3:0]));
      check({name, ".alu_b0"}, 32'(alu_b), 32'(bv[3:0]));
      check({name, ".alu_op"}, 32'(alu_op), 32'(o));
      check({name, ".less"}, 32'(alu_less), 32'd0);
    end
    cyc = 0;
    while (!done && cyc < 40) begin
      if (pester) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({name, ".latency"}, 32'(cyc), eill ? 32'd0 : 32'(N));
    check({name, ".result"}, 32'(result), 32'(er));
    check({name, ".cout"}, 32'(cout), 32'(ec));
    check({name, ".zero"}, 32'(zero), 32'(er == '0));
    check({name, ".illegal"}, 32'(illegal_op), 32'(eill));
    $display("[TB] %s op=%b a=%h b=%h -> result=%h cout=%b zero=%b ill=%b cycles=%0d",
             name, o, av, bv, result, cout, zero, illegal_op, cyc);
    @(posedge clk); #1;
    check({name, ".done_pulse"}, 32'(done), 32'd0);
    check({name, ".busy_end"}, 32'(busy), 32'd0);
    check({name, ".held"}, 32'(result), 32'(er));
    check({name, ".zero_held"}, 32'(zero), 32'(er == '0));
    check({name, ".ndone"}, 32'(done_count - dc0), 32'd1);
  endtask

  initial begin
    int dc0;
    rst_n = 1'b0; start = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.result", 32'(result), 32'd0);
    check("rst.flags", {29'b0, cout, zero, illegal_op}, 32'd0);
    check("rst.drive", {20'b0, alu_a, alu_b, alu_cin, alu_op}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("add_ripple", 3'b010, 16'h00FF, 16'h0001, 1'b0);
    do_op("sub_eq",     3'b110, 16'h1234, 16'h1234, 1'b0);
    do_op("slt_lt",     3'b111, 16'h0003, 16'h0005, 1'b0);
    do_op("slt_ge",     3'b111, 16'h0005, 16'h0003, 1'b0);
    do_op("and",        3'b000, 16'hF0F0, 16'hFF00, 1'b0);
    do_op("or",         3'b001, 16'hF0F0, 16'hFF00, 1'b0);
    do_op("illegal",    3'b011, 16'h1234, 16'h5678, 1'b1);
    do_op("add_pester", 3'b010, 16'h8001, 16'h7FFF, 1'b1);

    // Reset in the middle of a RUN.
    @(negedge clk);
    start = 1'b1; op_i = 3'b010; a_i = 16'hABCD; b_i = 16'h1111;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("mid.alu_a2", 32'(alu_a), 32'hB);
    dc0 = done_count;
    rst_n = 1'b0;
    #1;
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.result", 32'(result), 32'd0);
    check("mid.flags", {28'b0, done, cout, zero, illegal_op}, 32'd0);
    check("mid.drive", {20'b0, alu_a, alu_b, alu_cin, alu_op}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("mid.nodone", 32'(done_count - dc0), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_op("add_wrap", 3'b010, 16'hFFFF, 16'h0001, 1'b0);

    // Randomized operations, including illegal codes and busy-time starts.
    for (int i = 0; i < 30; i++) begin
      do_op("rand", 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
